// File: rtl/regfile_write_arbiter.sv
// Write-back arbiter: merges ALU and buffered LSU results onto one
// registered register-file write port, with a long-latency pending scoreboard.
module regfile_write_arbiter #(
    parameter int DataWidth = 32,
    parameter int NumRegs   = 32,
    parameter int AddrWidth = 5,
    parameter int FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alu_valid_i,
    input  logic [AddrWidth-1:0] alu_rd_i,
    input  logic [DataWidth-1:0] alu_data_i,
    input  logic                 lsu_valid_i,
    input  logic [AddrWidth-1:0] lsu_rd_i,
    input  logic [DataWidth-1:0] lsu_data_i,
    output logic                 lsu_ready_o,
    input  logic                 issue_valid_i,
    input  logic [AddrWidth-1:0] issue_rd_i,
    input  logic [AddrWidth-1:0] chk_rs1_i,
    input  logic [AddrWidth-1:0] chk_rs2_i,
    input  logic [AddrWidth-1:0] chk_rd_i,
    output logic                 hazard_o,
    output logic                 we_o,
    output logic [AddrWidth-1:0] waddr_o,
    output logic [DataWidth-1:0] wdata_o
);

    localparam int PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FifoDepth);

    // LSU result buffer (payload is unreset; validity lives in count_q)
    logic [AddrWidth-1:0] fifo_rd_q   [FifoDepth];
    logic [DataWidth-1:0] fifo_data_q [FifoDepth];
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic [NumRegs-1:0]   pending_q, pending_d;

    logic                 we_q, we_d;
    logic [AddrWidth-1:0] waddr_q, waddr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;

    logic alu_wr;
    logic lsu_acc;
    logic lsu_keep;
    logic fifo_nempty;
    logic deq;
    logic byp;
    logic enq;
    logic [AddrWidth-1:0] head_rd;
    logic [DataWidth-1:0] head_data;

    assign head_rd   = fifo_rd_q[rptr_q];
    assign head_data = fifo_data_q[rptr_q];

    assign lsu_ready_o = (count_q < FULL);
    assign hazard_o    = pending_q[chk_rs1_i] | pending_q[chk_rs2_i]
                       | pending_q[chk_rd_i];

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

    // Source selection: ALU first, then FIFO head, then LSU bypass
    always_comb begin
        alu_wr      = alu_valid_i & (alu_rd_i != '0);
        lsu_acc     = lsu_valid_i & lsu_ready_o;
        lsu_keep    = lsu_acc & (lsu_rd_i != '0);
        fifo_nempty = (count_q != '0);
        deq         = ~alu_wr & fifo_nempty;
        byp         = ~alu_wr & ~fifo_nempty & lsu_keep;
        enq         = lsu_keep & ~byp;

        we_d    = alu_wr | deq | byp;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (alu_wr) begin
            waddr_d = alu_rd_i;
            wdata_d = alu_data_i;
        end else if (deq) begin
            waddr_d = head_rd;
            wdata_d = head_data;
        end else if (byp) begin
            waddr_d = lsu_rd_i;
            wdata_d = lsu_data_i;
        end
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        wptr_d  = enq ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = deq ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (enq && !deq) begin
            count_d = count_q + 1'b1;
        end else if (deq && !enq) begin
            count_d = count_q - 1'b1;
        end
    end

    // Scoreboard: clear on LSU write-back, then a same-cycle issue re-sets
    always_comb begin
        pending_d = pending_q;
        if (deq) begin
            pending_d[head_rd] = 1'b0;
        end else if (byp) begin
            pending_d[lsu_rd_i] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != '0)) begin
            pending_d[issue_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // FIFO payload storage
    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_rd_q[wptr_q]   <= lsu_rd_i;
            fifo_data_q[wptr_q] <= lsu_data_i;
        end
    end

    // Control state and output register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            pending_q <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule
